// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller command port between a write (pixel drain) and a
// read (host readout) requester; round-robin with urgency override and a write run cap.
module mem_port_arbiter #(
  parameter int unsigned ADDR_SHIFT = 3,
  parameter int unsigned MAX_WR_RUN = 4,
  parameter logic [2:0]  CMD_WR     = 3'b000,
  parameter logic [2:0]  CMD_RD     = 3'b001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        calib_done,
  input  logic        wr_req,
  input  logic [23:0] wr_addr,
  input  logic        wr_urgent,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [23:0] rd_addr,
  output logic        rd_ack,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [29:0] cmd_addr,
  input  logic        cmd_full,
  output logic        busy,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int unsigned      RUN_W   = $clog2(MAX_WR_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_WR_RUN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_CMD   = 3'd2,
    S_ACK   = 3'd3,
    S_GUARD = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_grant_wr;
  logic             r_rd_at_grant;
  logic [23:0]      r_addr;
  logic             r_last_wr;
  logic [RUN_W-1:0] r_run_cnt;
  logic [15:0]      r_wr_count;
  logic [15:0]      r_rd_count;
  logic             w_any_req;
  logic             w_grant_wr;
  logic [RUN_W-1:0] w_run_next;
  logic [29:0]      w_cmd_addr;

  assign w_any_req  = wr_req | rd_req;
  assign w_cmd_addr = 30'(r_addr) << ADDR_SHIFT;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a stalled command waits on cmd_full indefinitely
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (calib_done && w_any_req) w_next_state = S_ARB;
        else                         w_next_state = S_IDLE;
      end
      S_ARB: begin
        if (w_any_req) w_next_state = S_CMD;
        else           w_next_state = S_IDLE;
      end
      S_CMD: begin
        if (!cmd_full) w_next_state = S_ACK;
        else           w_next_state = S_CMD;
      end
      S_ACK:   w_next_state = S_GUARD;
      S_GUARD: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant decision: lone requester wins, else urgency, run cap, then round-robin
  always_comb begin
    w_grant_wr = 1'b0;
    if (wr_req && !rd_req) begin
      w_grant_wr = 1'b1;
    end else if (!wr_req && rd_req) begin
      w_grant_wr = 1'b0;
    end else if (wr_urgent) begin
      w_grant_wr = 1'b1;
    end else if (r_run_cnt == RUN_MAX) begin
      w_grant_wr = 1'b0;
    end else begin
      w_grant_wr = ~r_last_wr;
    end
  end

  // A write with no competing read breaks the run; otherwise count up to the cap
  always_comb begin
    w_run_next = r_run_cnt;
    if (!r_rd_at_grant) begin
      w_run_next = {RUN_W{1'b0}};
    end else if (r_run_cnt == RUN_MAX) begin
      w_run_next = RUN_MAX;
    end else begin
      w_run_next = r_run_cnt + RUN_W'(1);
    end
  end

  // Grant latch and per-command bookkeeping, committed only when the ack goes out
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_grant_wr    <= 1'b0;
      r_rd_at_grant <= 1'b0;
      r_addr        <= 24'h000000;
      r_last_wr     <= 1'b0;
      r_run_cnt     <= {RUN_W{1'b0}};
      r_wr_count    <= 16'h0000;
      r_rd_count    <= 16'h0000;
    end else begin
      if (r_state == S_ARB && w_any_req) begin
        r_grant_wr    <= w_grant_wr;
        r_rd_at_grant <= rd_req;
        r_addr        <= w_grant_wr ? wr_addr : rd_addr;
      end
      if (r_state == S_ACK) begin
        if (r_grant_wr) begin
          r_wr_count <= r_wr_count + 16'd1;
          r_last_wr  <= 1'b1;
          r_run_cnt  <= w_run_next;
        end else begin
          r_rd_count <= r_rd_count + 16'd1;
          r_last_wr  <= 1'b0;
          r_run_cnt  <= {RUN_W{1'b0}};
        end
      end
    end
  end

  // Outputs decoded from state; cmd_en follows cmd_full in the same cycle
  always_comb begin
    cmd_en    = 1'b0;
    cmd_instr = 3'b000;
    cmd_addr  = 30'h00000000;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    if (r_state == S_CMD) begin
      cmd_en    = ~cmd_full;
      cmd_instr = r_grant_wr ? CMD_WR : CMD_RD;
      cmd_addr  = w_cmd_addr;
    end else if (r_state == S_ACK) begin
      wr_ack = r_grant_wr;
      rd_ack = ~r_grant_wr;
    end else begin
      cmd_en = 1'b0;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a transaction-timeline model predicts
// every output cycle by cycle; directed phases cover latency, gating and reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        calib_done;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic        wr_urgent;
  logic        wr_ack;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_ack;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [29:0] cmd_addr;
  logic        cmd_full;
  logic        busy;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_urgent(wr_urgent), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_full(cmd_full),
    .busy(busy), .wr_count(wr_count), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus knobs, percent chances
  int p_wr = 0, p_rd = 0, p_urg = 0, p_full = 0, p_cal = 100;
  bit saw_wr_ack = 1'b0, saw_rd_ack = 1'b0;

  // reference model: a transaction timeline measured in cycles since acceptance
  bit          m_act = 1'b0;
  int          m_age = 0;
  int          m_ack_age = -1;
  bit          m_gw = 1'b0;
  bit          m_rd_at = 1'b0;
  bit          m_last_wr = 1'b0;
  int          m_run = 0;
  logic [23:0] m_addr = 24'h0;
  logic [15:0] m_wrc = 16'h0;
  logic [15:0] m_rdc = 16'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      m_act = 1'b0; m_age = 0; m_ack_age = -1;
      m_last_wr = 1'b0; m_run = 0; m_wrc = 16'h0; m_rdc = 16'h0;
    end else if (!m_act) begin
      if (calib_done && (wr_req || rd_req)) begin
        m_act = 1'b1; m_age = 1; m_ack_age = -1;
      end
    end else begin
      if (m_age == 1) begin
        if (wr_req && rd_req) m_gw = wr_urgent ? 1'b1 : (m_run == 4) ? 1'b0 : !m_last_wr;
        else                  m_gw = wr_req;
        m_rd_at = rd_req;
        m_addr  = m_gw ? wr_addr : rd_addr;
      end else if (m_ack_age < 0) begin
        if (!cmd_full) m_ack_age = m_age + 1;
      end else if (m_age == m_ack_age) begin
        if (m_gw) begin
          m_wrc++;
          m_last_wr = 1'b1;
          m_run = m_rd_at ? ((m_run < 4) ? m_run + 1 : 4) : 0;
        end else begin
          m_rdc++;
          m_last_wr = 1'b0;
          m_run = 0;
        end
      end
      m_age++;
      if (m_ack_age >= 0 && m_age == m_ack_age + 2) m_act = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    if (saw_wr_ack) begin
      wr_req = 1'b0; saw_wr_ack = 1'b0;
    end else if (!wr_req && int'($urandom_range(99)) < p_wr) begin
      wr_req = 1'b1; wr_addr = 24'($urandom);
    end
    if (saw_rd_ack) begin
      rd_req = 1'b0; saw_rd_ack = 1'b0;
    end else if (!rd_req && int'($urandom_range(99)) < p_rd) begin
      rd_req = 1'b1; rd_addr = 24'($urandom);
    end
    wr_urgent  = int'($urandom_range(99)) < p_urg;
    cmd_full   = int'($urandom_range(99)) < p_full;
    calib_done = int'($urandom_range(99)) < p_cal;
  endtask

  task automatic compare_all();
    bit in_cmd, in_ack;
    in_cmd = m_act && m_age >= 2 && m_ack_age < 0;
    in_ack = m_act && m_age == m_ack_age;
    check_val("busy", busy, m_act);
    check_val("cmd_en", cmd_en, in_cmd && !cmd_full);
    check_val("wr_ack", wr_ack, in_ack && m_gw);
    check_val("rd_ack", rd_ack, in_ack && !m_gw);
    check_val("wr_count", wr_count, m_wrc);
    check_val("rd_count", rd_count, m_rdc);
    if (in_cmd) begin
      check_val("cmd_instr", cmd_instr, m_gw ? 3'b000 : 3'b001);
      check_val("cmd_addr", cmd_addr, {3'b000, m_addr, 3'b000});
    end
    saw_wr_ack = wr_ack;
    saw_rd_ack = rd_ack;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive_inputs();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    p_wr = 0; p_rd = 0; p_urg = 0; p_full = 0; p_cal = 100;
    run(25);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] wr0, rd0;
    bit reached;
    reset_n = 1'b0; calib_done = 1'b0; wr_req = 1'b0; wr_addr = 24'h0;
    wr_urgent = 1'b0; rd_req = 1'b0; rd_addr = 24'h0; cmd_full = 1'b0;
    run(3);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_cmd_en", cmd_en, 1'b0);
    check_val("rst_cmd_addr", cmd_addr, 30'h0);
    check_val("rst_wr_count", wr_count, 16'h0);
    reset_n = 1'b1;
    run(1);

    // single write: cmd_en two cycles after sampling, ack one later
    wr_req = 1'b1; wr_addr = 24'h000010;
    run(2);
    check_val("sw_cmd_en", cmd_en, 1'b1);
    check_val("sw_cmd_instr", cmd_instr, 3'b000);
    check_val("sw_cmd_addr", cmd_addr, 30'h00000080);
    run(1);
    check_val("sw_wr_ack", wr_ack, 1'b1);
    run(1);
    check_val("sw_wr_count", wr_count, 16'd1);
    drain();

    // calibration gate, then first tie after reset goes to write
    do_reset();
    p_cal = 0; p_wr = 100; p_rd = 100;
    run(20);
    check_val("cal_gate_wr", wr_count, 16'd0);
    check_val("cal_gate_rd", rd_count, 16'd0);
    p_cal = 100; calib_done = 1'b1;
    run(4);
    check_val("cal_first_wr", wr_count, 16'd1);
    check_val("cal_first_rd", rd_count, 16'd0);

    // alternation with both requesters saturated
    run(40);
    check_val("alt_balance", (wr_count > rd_count ? wr_count - rd_count : rd_count - wr_count) <= 16'd1, 1'b1);

    // urgency starves reads; dropping urgency forces a read next
    p_urg = 100;
    run(10);
    wr0 = wr_count; rd0 = rd_count;
    run(60);
    check_val("urg_no_reads", rd_count - rd0, 16'd0);
    check_val("urg_ten_writes", (wr_count - wr0) >= 16'd10, 1'b1);
    p_urg = 0;
    run(20);
    drain();

    // backpressure: seven stalled cycles in the command phase
    p_full = 100;
    rd_req = 1'b1; rd_addr = 24'($urandom);
    rd0 = rd_count;
    run(8);
    check_val("bp_stalled", cmd_en, 1'b0);
    p_full = 0; cmd_full = 1'b0;
    #1;
    check_val("bp_release_en", cmd_en, 1'b1);
    run(10);
    check_val("bp_single_ack", rd_count - rd0, 16'd1);

    // randomised mix
    p_wr = 40; p_rd = 40; p_urg = 25; p_full = 30; p_cal = 90;
    run(600);
    drain();

    // reset while stalled in the command phase
    p_full = 100;
    wr_req = 1'b1; wr_addr = 24'($urandom);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step();
      reached = m_act && m_age >= 2 && m_ack_age < 0;
    end
    check_val("rm_reach_cmd", reached, 1'b1);
    reset_n = 1'b0;
    run(1);
    check_val("rm_busy", busy, 1'b0);
    check_val("rm_cmd_en", cmd_en, 1'b0);
    check_val("rm_wr_ack", wr_ack, 1'b0);
    check_val("rm_cmd_instr", cmd_instr, 3'b000);
    check_val("rm_cmd_addr", cmd_addr, 30'h0);
    check_val("rm_wr_count", wr_count, 16'd0);
    check_val("rm_rd_count", rd_count, 16'd0);
    reset_n = 1'b1; p_full = 0;
    run(10);
    check_val("rm_reserved", wr_count, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
